// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and line levels for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit queue with registered pointers and occupancy count.
// Pushes on a full queue are refused even if a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign o_full  = (count_q == DEPTH_C);
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_rdata = mem_q[rd_ptr_q];

   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the count alone defines which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
   end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - queued UART transmitter with runtime divisor and one/two stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DIV_WIDTH-1:0]          i_clks_per_bit,
   input  logic                          i_two_stop,
`ifdef UART_TX_PARITY_EN
   input  logic                          i_parity_odd,
`endif
   input  logic                          i_tx_dv,
   input  logic [DATA_BITS-1:0]          i_tx_byte,
   output logic                          o_tx_ready,
   output logic                          o_tx_serial,
   output logic                          o_tx_active,
   output logic                          o_tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int             BW       = $clog2(DATA_BITS);
   localparam int             CW       = DIV_WIDTH + 1;
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   tx_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic                   two_stop_q, two_stop_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_odd_q, parity_odd_d;
`endif
   logic                   serial_q, serial_d;

   logic                   fifo_pop, fifo_empty, fifo_full;
   logic [DATA_BITS-1:0]   fifo_rdata;
   logic                   load, done;
   logic [CW-1:0]          div_ext, stop_len;
   logic                   bit_end, stop_end;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_tx_dv),
      .i_wdata (i_tx_byte),
      .i_pop   (fifo_pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (o_fifo_count)
   );

   assign div_ext  = {1'b0, div_q};
   assign stop_len = two_stop_q ? {div_q, 1'b0} : div_ext;
   assign bit_end  = (cnt_q == div_ext - CW'(1));
   assign stop_end = (cnt_q == stop_len - CW'(1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      data_d     = data_q;
      div_d      = div_q;
      two_stop_d = two_stop_q;
`ifdef UART_TX_PARITY_EN
      parity_odd_d = parity_odd_q;
`endif
      load     = 1'b0;
      done     = 1'b0;
      fifo_pop = 1'b0;
      serial_d = LINE_IDLE;

      case (state_q)
         ST_IDLE: load = !fifo_empty;
         ST_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         ST_STOP: begin
            if (stop_end) begin
               done  = 1'b1;
               cnt_d = '0;
               if (fifo_empty) state_d = ST_IDLE;
               else            load    = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase

      // Frame settings are captured only here, so mid-frame input changes wait for the next frame.
      if (load) begin
         fifo_pop   = 1'b1;
         data_d     = fifo_rdata;
         div_d      = (i_clks_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_clks_per_bit;
         two_stop_d = i_two_stop;
`ifdef UART_TX_PARITY_EN
         parity_odd_d = i_parity_odd;
`endif
         cnt_d   = '0;
         bit_d   = '0;
         state_d = ST_START;
      end

      // The line register is loaded with the level of the state being entered.
      case (state_d)
         ST_START:  serial_d = LINE_START;
         ST_DATA:   serial_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: serial_d = (^data_d) ^ parity_odd_d;
`endif
         ST_STOP:   serial_d = LINE_STOP;
         default:   serial_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         div_q      <= '0;
         two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_odd_q <= 1'b0;
`endif
         serial_q   <= LINE_IDLE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         div_q      <= div_d;
         two_stop_q <= two_stop_d;
`ifdef UART_TX_PARITY_EN
         parity_odd_q <= parity_odd_d;
`endif
         serial_q   <= serial_d;
      end
   end

   assign o_tx_serial = serial_q;
   assign o_tx_active = (state_q != ST_IDLE);
   assign o_tx_done   = done;
   assign o_tx_ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param against a per-clock line model.
// Parity cases are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_param;

   localparam int DB    = 8;
   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int CNTW  = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   cpb;
   logic            two_stop;
`ifdef UART_TX_PARITY_EN
   logic            parity_odd;
`endif
   logic            tx_dv;
   logic [DB-1:0]   tx_byte;
   logic            tx_ready, tx_serial, tx_active, tx_done;
   logic [CNTW-1:0] fifo_count;

   always #5 clk = ~clk;

   uart_tx_param #(
      .DATA_BITS  (DB),
      .FIFO_DEPTH (DEPTH),
      .DIV_WIDTH  (DW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_clks_per_bit (cpb),
      .i_two_stop     (two_stop),
`ifdef UART_TX_PARITY_EN
      .i_parity_odd   (parity_odd),
`endif
      .i_tx_dv        (tx_dv),
      .i_tx_byte      (tx_byte),
      .o_tx_ready     (tx_ready),
      .o_tx_serial    (tx_serial),
      .o_tx_active    (tx_active),
      .o_tx_done      (tx_done),
      .o_fifo_count   (fifo_count)
   );

   typedef struct packed {
      logic ser;
      logic done;
   } samp_t;

   samp_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   bit    checking = 1'b0;
   int    act_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected line level for every clock of one frame, built from the frame format.
   task automatic add_frame(input logic [DB-1:0] d, input int div, input bit two, input bit odd);
      int    n;
      logic  bits[$];
      samp_t s;
      n = (div < 2) ? 2 : div;
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(d[i]);
      if (PAR_EN != 0) bits.push_back((^d) ^ odd);
      bits.push_back(1'b1);
      if (two) bits.push_back(1'b1);
      foreach (bits[b]) begin
         for (int k = 0; k < n; k++) exp_q.push_back('{ser: bits[b], done: 1'b0});
      end
      s = exp_q.pop_back();
      s.done = 1'b1;
      exp_q.push_back(s);
   endtask

   task automatic cyc();
      samp_t s;
      @(posedge clk);
      #1;
      if (checking && exp_q.size() > 0) begin
         s = exp_q.pop_front();
         chk("serial", 32'(tx_serial), 32'(s.ser));
         chk("done", 32'(tx_done), 32'(s.done));
         chk("active", 32'(tx_active), 32'd1);
         act_cycles++;
      end
   endtask

   task automatic push(input logic [DB-1:0] d);
      tx_byte = d;
      tx_dv   = 1'b1;
      cyc();
      tx_dv   = 1'b0;
   endtask

   task automatic start_frame(input logic [DB-1:0] d, input int div, input bit two, input bit odd);
      cpb      = DW'(div);
      two_stop = two;
`ifdef UART_TX_PARITY_EN
      parity_odd = odd;
`endif
      push(d);
      chk("pre_start_line", 32'(tx_serial), 32'd1);
      add_frame(d, div, two, odd);
      checking   = 1'b1;
      act_cycles = 0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 5000) begin
         cyc();
         guard++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      checking = 1'b0;
      cyc();
      chk("idle_serial", 32'(tx_serial), 32'd1);
      chk("idle_active", 32'(tx_active), 32'd0);
   endtask

   initial begin
      logic [DB-1:0] d;
      int            dv;
      bit            tw;

      rst      = 1'b1;
      cpb      = DW'(4);
      two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd = 1'b0;
`endif
      tx_dv    = 1'b0;
      tx_byte  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_serial", 32'(tx_serial), 32'd1);
      chk("rst_active", 32'(tx_active), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      cyc();

      start_frame(8'hA5, 4, 1'b0, 1'b0);
      drain();
      chk("a5_frame_len", 32'(act_cycles), 32'((10 + PAR_EN) * 4));

      for (int t = 0; t < 4; t++) begin
         d  = DB'($urandom);
         dv = int'($urandom_range(0, 6));
         tw = 1'($urandom_range(0, 1));
         start_frame(d, dv, tw, 1'($urandom_range(0, 1)));
         drain();
      end

      start_frame(DB'($urandom), 0, 1'b0, 1'b0);
      drain();
      chk("div0_frame_len", 32'(act_cycles), 32'((10 + PAR_EN) * 2));
      start_frame(DB'($urandom), 1, 1'b0, 1'b0);
      drain();
      chk("div1_frame_len", 32'(act_cycles), 32'((10 + PAR_EN) * 2));

      start_frame(DB'($urandom), 3, 1'b1, 1'b0);
      repeat (5) cyc();
      cpb = DW'(8);
      d = DB'($urandom);
      push(d);
      add_frame(d, 8, 1'b1, 1'b0);
      drain();
      chk("two_stop_len", 32'(act_cycles), 32'((11 + PAR_EN) * 3 + (11 + PAR_EN) * 8));

      start_frame(DB'($urandom), 2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         d = DB'($urandom);
         push(d);
         add_frame(d, 2, 1'b0, 1'b0);
      end
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_ready", 32'(tx_ready), 32'd0);
      push(DB'($urandom));
      chk("drop_count", 32'(fifo_count), 32'd4);
      drain();
      chk("b2b_len", 32'(act_cycles), 32'(5 * (10 + PAR_EN) * 2));

`ifdef UART_TX_PARITY_EN
      start_frame(8'h07, 4, 1'b0, 1'b0);
      drain();
      chk("par_even_len", 32'(act_cycles), 32'd44);
      start_frame(8'h07, 4, 1'b0, 1'b1);
      drain();
      chk("par_odd_len", 32'(act_cycles), 32'd44);
`endif

      start_frame(DB'($urandom), 4, 1'b0, 1'b0);
      push(DB'($urandom));
      repeat (17) cyc();
      checking = 1'b0;
      exp_q.delete();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_serial", 32'(tx_serial), 32'd1);
      chk("rst_mid_count", 32'(fifo_count), 32'd0);
      chk("rst_mid_active", 32'(tx_active), 32'd0);
      chk("rst_mid_done", 32'(tx_done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         chk("post_rst_done", 32'(tx_done), 32'd0);
         chk("post_rst_serial", 32'(tx_serial), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
